led_matrix_scan_driver: RTL and testbench

Time-multiplexed scan driver for the LED matrix. It supersedes the purely combinational column decoder with a parametrised column count, a programmable dwell time, and inter-column blanking to suppress ghosting. A double-buffered frame store is loaded by the application logic and swapped only on frame boundaries. It sits between the display-content logic and the matrix pins, and produces the one-hot column enables and row data directly.

---
 rtl/led_matrix_scan_driver_if.sv | 28 ++
 rtl/led_matrix_scan_driver.sv | 191 +++++++++++++++++++
 tb/tb_led_matrix_scan_driver.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/led_matrix_scan_driver_if.sv
// Port bundle between the display-content logic and the scan driver.
// master = application side, slave = scan driver.
interface led_matrix_scan_driver_if #(
  parameter int NUM_COLS = 5,
  parameter int NUM_ROWS = 7
);
  localparam int CIW = $clog2(NUM_COLS);

  logic                enable;
  logic                wr_en;
  logic [CIW-1:0]      wr_col;
  logic [NUM_ROWS-1:0] wr_data;
  logic                swap_req;
  logic [NUM_COLS-1:0] column_status;
  logic [NUM_ROWS-1:0] row_data;
  logic                frame_start;
  logic                swap_done;

  modport master (
    output enable, wr_en, wr_col, wr_data, swap_req,
    input  column_status, row_data, frame_start, swap_done
  );

  modport slave (
    input  enable, wr_en, wr_col, wr_data, swap_req,
    output column_status, row_data, frame_start, swap_done
  );
endinterface

// File: rtl/led_matrix_scan_driver.sv
// Time-multiplexed LED matrix scan driver: double-buffered frame store,
// programmable dwell and blanking, swap only at frame boundaries.

// One column of the frame store: two row words, one front and one back.
module led_matrix_col_lane #(
  parameter int IDX      = 0,
  parameter int NUM_ROWS = 7,
  parameter int CIW      = 3
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CIW-1:0]      wr_col,
  input  logic [NUM_ROWS-1:0] wr_data,
  input  logic                sel,
  input  logic                sel_nx,
  input  logic                drive_nx,
  input  logic [CIW-1:0]      col_nx,
  output logic                col_en_nx,
  output logic [NUM_ROWS-1:0] row_nx
);
  localparam logic [CIW-1:0] IDX_C = CIW'(IDX);

  logic [NUM_ROWS-1:0] b0, b1, front_nx;
  logic                wr_hit;

  // out-of-range wr_col never matches any lane index, so it is dropped
  assign wr_hit = wr_en && (wr_col == IDX_C);

  // sel=0: b0 front / b1 back; sel=1: b1 front / b0 back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b0 <= '0;
      b1 <= '0;
    end else if (wr_hit) begin
      if (sel) b0 <= wr_data;
      else     b1 <= wr_data;
    end
  end

  // a write landing in the swap cycle goes to the buffer about to become front
  always_comb begin
    front_nx = sel_nx ? b1 : b0;
    if (wr_hit && (sel_nx != sel)) front_nx = wr_data;
  end

  assign col_en_nx = drive_nx && (col_nx == IDX_C);
  assign row_nx    = col_en_nx ? front_nx : '0;
endmodule

module led_matrix_scan_driver #(
  parameter int NUM_COLS     = 5,
  parameter int NUM_ROWS     = 7,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
)(
  input logic                    clk,
  input logic                    reset,
  led_matrix_scan_driver_if.slave bus
);
  localparam int CIW  = $clog2(NUM_COLS);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2((CMAX > 2) ? CMAX : 2);
  localparam logic [CW-1:0]  DW_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]  BL_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CIW-1:0] COL_LAST = CIW'(NUM_COLS - 1);

  typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [CIW-1:0] col, col_nx;
  logic           run, run_nx;
  logic           sel, sel_nx;
  logic           pend, pend_nx;
  logic           swap_now, drive_nx;

  logic [NUM_COLS-1:0]               col_en_nx;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] lane_row_nx;
  logic [NUM_ROWS-1:0]               row_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_BLANK;
      cnt   <= '0;
      col   <= '0;
      run   <= 1'b0;
      sel   <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      col   <= col_nx;
      run   <= run_nx;
      sel   <= sel_nx;
      pend  <= pend_nx;
    end
  end

  // run marks an active scan; the cycle that sets it is the leading BLANK
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    col_nx   = col;
    run_nx   = run;
    sel_nx   = sel;
    pend_nx  = pend | bus.swap_req;
    swap_now = 1'b0;
    if (!bus.enable) begin
      state_nx = S_BLANK;
      cnt_nx   = '0;
      col_nx   = '0;
      run_nx   = 1'b0;
    end else if (!run) begin
      run_nx   = 1'b1;
      state_nx = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
      cnt_nx   = '0;
      col_nx   = '0;
    end else begin
      case (state)
        S_BLANK: begin
          if (cnt == BL_LAST) begin
            state_nx = S_DRIVE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == DW_LAST) begin
            state_nx = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
            cnt_nx   = '0;
            if (col == COL_LAST) begin
              col_nx = '0;
              if (pend || bus.swap_req) begin
                swap_now = 1'b1;
                sel_nx   = ~sel;
                pend_nx  = 1'b0;
              end
            end else begin
              col_nx = col + 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = S_BLANK;
      endcase
    end
  end

  assign drive_nx = run_nx && (state_nx == S_DRIVE);

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
    led_matrix_col_lane #(
      .IDX(i), .NUM_ROWS(NUM_ROWS), .CIW(CIW)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (bus.wr_en),
      .wr_col    (bus.wr_col),
      .wr_data   (bus.wr_data),
      .sel       (sel),
      .sel_nx    (sel_nx),
      .drive_nx  (drive_nx),
      .col_nx    (col_nx),
      .col_en_nx (col_en_nx[i]),
      .row_nx    (lane_row_nx[i])
    );
  end

  // only the active lane contributes a non-zero word
  always_comb begin
    row_nx = '0;
    for (int i = 0; i < NUM_COLS; i++) row_nx = row_nx | lane_row_nx[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.column_status <= '0;
      bus.row_data      <= '0;
      bus.frame_start   <= 1'b0;
      bus.swap_done     <= 1'b0;
    end else begin
      bus.column_status <= col_en_nx;
      bus.row_data      <= row_nx;
      bus.frame_start   <= drive_nx && (col_nx == '0) && (cnt_nx == '0);
      bus.swap_done     <= swap_now;
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench: scan timing, double-buffer swap, enable drop, async reset,
// and a BLANK_CYCLES=0 / 8-column instance.
module tb_led_matrix_scan_driver;
  localparam int NC   = 5;
  localparam int NR   = 7;
  localparam int DW   = 4;
  localparam int BL   = 1;
  localparam int NCB  = 8;
  localparam int COLP = BL + DW;
  localparam int FRMP = NC * COLP;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  led_matrix_scan_driver_if #(.NUM_COLS(NC),  .NUM_ROWS(NR)) bus_a();
  led_matrix_scan_driver_if #(.NUM_COLS(NCB), .NUM_ROWS(NR)) bus_b();

  led_matrix_scan_driver #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  led_matrix_scan_driver #(
    .NUM_COLS(NCB), .NUM_ROWS(NR), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  int t, tb_t, swap_t;
  logic off;
  logic [NR-1:0] fr_pre [NC];
  logic [NR-1:0] fr_post[NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, ".cs"},  32'(bus_a.column_status), 32'd0);
    chk({tag, ".row"}, 32'(bus_a.row_data),      32'd0);
    chk({tag, ".fs"},  32'(bus_a.frame_start),   32'd0);
    chk({tag, ".sd"},  32'(bus_a.swap_done),     32'd0);
  endtask

  // t = edges since scan start; cycle 0 blank, then COLP-periodic columns
  task automatic step_a(input string tag);
    int m, c;
    logic [NC-1:0] ecs;
    logic [NR-1:0] erow;
    logic efs, esd;
    tick();
    t++;
    ecs = '0; erow = '0; efs = 1'b0; esd = 1'b0;
    if (!off && t >= 1) begin
      m = (t - 1) % FRMP;
      c = m / COLP;
      if ((m % COLP) < DW) begin
        ecs  = NC'(1) << c;
        erow = (t > swap_t) ? fr_post[c] : fr_pre[c];
        efs  = (m == 0);
      end
    end
    if (!off) esd = (t == swap_t);
    chk({tag, ".cs"},  32'(bus_a.column_status), 32'(ecs));
    chk({tag, ".row"}, 32'(bus_a.row_data),      32'(erow));
    chk({tag, ".fs"},  32'(bus_a.frame_start),   32'(efs));
    chk({tag, ".sd"},  32'(bus_a.swap_done),     32'(esd));
  endtask

  task automatic step_b();
    logic [NCB-1:0] ecs;
    tick();
    tb_t++;
    ecs = NCB'(1) << ((tb_t / DW) % NCB);
    chk("sweep.cs",     32'(bus_b.column_status),          32'(ecs));
    chk("sweep.onehot", 32'($onehot(bus_b.column_status)), 32'd1);
    chk("sweep.fs",     32'(bus_b.frame_start),            32'((tb_t % (NCB * DW)) == 0));
    chk("sweep.row",    32'(bus_b.row_data),               32'd0);
  endtask

  initial begin
    bus_a.enable = 1'b1; bus_a.wr_en = 1'b0; bus_a.wr_col = '0;
    bus_a.wr_data = '0;  bus_a.swap_req = 1'b0;
    bus_b.enable = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_col = '0;
    bus_b.wr_data = '0;  bus_b.swap_req = 1'b0;
    off = 1'b0; swap_t = 1000;
    for (int c = 0; c < NC; c++) begin fr_pre[c] = '0; fr_post[c] = '0; end

    // reset state
    #1;
    chk_zero_a("rst");
    chk("rst_b.cs", 32'(bus_b.column_status), 32'd0);
    repeat (2) tick();
    reset = 1'b0; t = -1;

    // basic scan, no writes: frame_start at t=1,26,51
    repeat (51) step_a("scan");

    // write back buffer, out-of-range write, mid-frame swap request
    reset = 1'b1; tick(); reset = 1'b0; t = -1;
    for (int c = 0; c < NC; c++) begin fr_pre[c] = '0; fr_post[c] = NR'(1) << c; end
    swap_t = 25;
    for (int c = 0; c < NC; c++) begin
      bus_a.wr_en = 1'b1; bus_a.wr_col = 3'(c); bus_a.wr_data = NR'(1) << c;
      step_a("wr");
    end
    bus_a.wr_col = 3'd5; bus_a.wr_data = 7'h7f;
    step_a("wr_oob");
    bus_a.wr_en = 1'b0;
    repeat (2) step_a("pre_swap");
    bus_a.swap_req = 1'b1; step_a("swreq"); bus_a.swap_req = 1'b0;
    while (t < 55) step_a("swap1");

    // swap_req and a write both in the last col-4 DRIVE cycle
    fr_pre  = fr_post;
    fr_post = '{7'h00, 7'h00, 7'h55, 7'h00, 7'h00};
    swap_t  = 75;
    while (t < 74) step_a("bnd");
    bus_a.swap_req = 1'b1; bus_a.wr_en = 1'b1; bus_a.wr_col = 3'd2; bus_a.wr_data = 7'h55;
    step_a("bnd_swap");
    bus_a.swap_req = 1'b0; bus_a.wr_en = 1'b0;
    while (t < 100) step_a("bnd_post");

    // enable drop during column 2 with a swap pending
    fr_pre  = fr_post;
    fr_post = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    swap_t  = 1000;
    while (t < 102) step_a("drop_pre");
    bus_a.swap_req = 1'b1; step_a("pend"); bus_a.swap_req = 1'b0;
    while (t < 112) step_a("drop_pre");
    bus_a.enable = 1'b0; off = 1'b1;
    repeat (3) step_a("en_off");
    bus_a.enable = 1'b1; off = 1'b0; t = -1; swap_t = 25;
    while (t < 33) step_a("restart");

    // asynchronous reset while column 1 is driven with row 02
    #2 reset = 1'b1;
    #1 chk_zero_a("rst_async");
    tick();
    reset = 1'b0; t = -1;
    for (int c = 0; c < NC; c++) begin fr_pre[c] = '0; fr_post[c] = '0; end
    swap_t = 25;
    while (t < 4) step_a("post_rst");
    bus_a.swap_req = 1'b1; step_a("post_rst_req"); bus_a.swap_req = 1'b0;
    while (t < 50) step_a("post_rst");

    // 8 columns, no blanking: back-to-back, 32-cycle frame
    chk("sweep_idle.cs", 32'(bus_b.column_status), 32'd0);
    bus_b.enable = 1'b1; tb_t = -1;
    repeat (70) step_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
